rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port between three requesters:
//   - pipeline writeback (WB)
//   - interrupt link write (INT)
//   - exception link write (EXC)

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_pend_slot.sv | 71 +++++++
 rtl/rf_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// pending-slot state encoding and requester ids.
package rf_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [0:0] SLOT_EMPTY   = 1'b0;
  localparam logic [0:0] SLOT_PENDING = 1'b1;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_WB   = 2'd1,
    REQ_INT  = 2'd2,
    REQ_EXC  = 2'd3
  } req_id_e;

endpackage

// File: rtl/rf_pend_slot.sv
// One-entry parking slot for a deferred register write (INT or EXC link write),
// with a wait counter that raises starve after MAX_WAIT ungranted cycles.
module rf_pend_slot
  import rf_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          grant,
  input  logic          clear,
  output logic          pending,
  output logic          ready,
  output logic          starve,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [0:0]    state_r;
  logic [CW-1:0] wait_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_r;

  // Slot state, payload and saturating wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SLOT_EMPTY;
      wait_r  <= '0;
      addr_r  <= '0;
      data_r  <= '0;
    end else begin
      case (state_r)
        SLOT_EMPTY: begin
          if (fill) begin
            state_r <= SLOT_PENDING;
            addr_r  <= fill_addr;
            data_r  <= fill_data;
            wait_r  <= '0;
          end
        end
        SLOT_PENDING: begin
          if (grant || clear) begin
            state_r <= SLOT_EMPTY;
            wait_r  <= '0;
          end else if (wait_r != WAIT_MAX) begin
            wait_r <= wait_r + CW'(1);
          end
        end
        default: begin
          state_r <= SLOT_EMPTY;
          wait_r  <= '0;
        end
      endcase
    end
  end

  assign pending = (state_r == SLOT_PENDING);
  assign ready   = (state_r == SLOT_EMPTY);
  assign starve  = pending && (wait_r == WAIT_MAX);
  assign addr    = addr_r;
  assign data    = data_r;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter for WB, INT and EXC writes with starvation
// guard. Lookup ports are live only when RF_WRITE_BYPASS_EN is defined.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          int_valid,
  output logic          int_ready,
  input  logic [AW-1:0] int_addr,
  input  logic [DW-1:0] int_data,
  input  logic          exc_valid,
  output logic          exc_ready,
  input  logic [AW-1:0] exc_addr,
  input  logic [DW-1:0] exc_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] lk_addr0,
  input  logic [AW-1:0] lk_addr1,
  output logic          lk_hit0,
  output logic          lk_hit1,
  output logic [DW-1:0] lk_data0,
  output logic [DW-1:0] lk_data1
);

  logic          int_pend_s, int_starve_s, int_fill_s, int_clear_s, int_grant_s;
  logic          exc_pend_s, exc_starve_s, exc_fill_s, exc_clear_s, exc_grant_s;
  logic [AW-1:0] int_addr_r, exc_addr_r;
  logic [DW-1:0] int_data_r, exc_data_r;
  logic          wb_live_s, int_acc_s, exc_live_s, rr_flip_s;
  logic          rr_exc_r;
  req_id_e       gnt_id_s;

  assign wb_ready   = ~(int_starve_s | exc_starve_s);
  assign wb_live_s  = wb_valid && wb_ready && (wb_addr != '0);
  assign int_acc_s  = int_valid && int_ready && (int_addr != '0);
  assign exc_live_s = exc_valid && exc_ready && (exc_addr != '0);

  // WB is newest, then EXC, then INT: an older same-address write is dropped.
  assign exc_fill_s  = exc_live_s && !(wb_live_s && (wb_addr == exc_addr));
  assign int_fill_s  = int_acc_s && !(wb_live_s && (wb_addr == int_addr))
                                 && !(exc_live_s && (exc_addr == int_addr));
  assign int_clear_s = (wb_live_s && (wb_addr == int_addr_r))
                    || (exc_live_s && (exc_addr == int_addr_r));
  assign exc_clear_s = wb_live_s && (wb_addr == exc_addr_r);

  rf_pend_slot #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) u_int_slot (
    .clk       (clk),
    .rst       (rst),
    .fill      (int_fill_s),
    .fill_addr (int_addr),
    .fill_data (int_data),
    .grant     (int_grant_s),
    .clear     (int_clear_s),
    .pending   (int_pend_s),
    .ready     (int_ready),
    .starve    (int_starve_s),
    .addr      (int_addr_r),
    .data      (int_data_r)
  );

  rf_pend_slot #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) u_exc_slot (
    .clk       (clk),
    .rst       (rst),
    .fill      (exc_fill_s),
    .fill_addr (exc_addr),
    .fill_data (exc_data),
    .grant     (exc_grant_s),
    .clear     (exc_clear_s),
    .pending   (exc_pend_s),
    .ready     (exc_ready),
    .starve    (exc_starve_s),
    .addr      (exc_addr_r),
    .data      (exc_data_r)
  );

  // Single winner per cycle: live WB, else round-robin between pending slots.
  always_comb begin
    gnt_id_s = REQ_NONE;
    if (wb_live_s) begin
      gnt_id_s = REQ_WB;
    end else if (int_pend_s && exc_pend_s) begin
      if (rr_exc_r) begin
        gnt_id_s = REQ_EXC;
      end else begin
        gnt_id_s = REQ_INT;
      end
    end else if (int_pend_s) begin
      gnt_id_s = REQ_INT;
    end else if (exc_pend_s) begin
      gnt_id_s = REQ_EXC;
    end else begin
      gnt_id_s = REQ_NONE;
    end
  end

  assign int_grant_s = (gnt_id_s == REQ_INT);
  assign exc_grant_s = (gnt_id_s == REQ_EXC);
  // Pointer moves only on contested slot grants, so a drained pair hands the next pair to the loser.
  assign rr_flip_s   = !wb_live_s && int_pend_s && exc_pend_s;

  // Registered write port and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_exc_r <= 1'b0;
    end else begin
      if (rr_flip_s) begin
        rr_exc_r <= ~rr_exc_r;
      end
      case (gnt_id_s)
        REQ_WB: begin
          rf_we    <= 1'b1;
          rf_waddr <= wb_addr;
          rf_wdata <= wb_data;
        end
        REQ_INT: begin
          rf_we    <= 1'b1;
          rf_waddr <= int_addr_r;
          rf_wdata <= int_data_r;
        end
        REQ_EXC: begin
          rf_we    <= 1'b1;
          rf_waddr <= exc_addr_r;
          rf_wdata <= exc_data_r;
        end
        default: begin
          rf_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [DW:0] r;
    r = '0;
    if (a == '0) begin
      r = '0;
    end else if (exc_pend_s && (exc_addr_r == a)) begin
      r = {1'b1, exc_data_r};
    end else if (int_pend_s && (int_addr_r == a)) begin
      r = {1'b1, int_data_r};
    end else if (rf_we && (rf_waddr == a)) begin
      r = {1'b1, rf_wdata};
    end else begin
      r = '0;
    end
    return r;
  endfunction

  // Bypass lookup against slots and the in-flight write register.
  always_comb begin
    {lk_hit0, lk_data0} = lookup(lk_addr0);
    {lk_hit1, lk_data1} = lookup(lk_addr1);
  end
`else
  logic unused_lk_s;
  assign unused_lk_s = ^{lk_addr0, lk_addr1};
  assign lk_hit0  = 1'b0;
  assign lk_hit1  = 1'b0;
  assign lk_data0 = '0;
  assign lk_data1 = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scenario bench for rf_write_arbiter: expected writes are queued at stimulus
// time and popped by a monitor whenever rf_we is seen.
module tb_rf_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0, int_valid = 1'b0, exc_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0, int_addr = '0, exc_addr = '0;
  logic [DW-1:0] wb_data = '0, int_data = '0, exc_data = '0;
  logic [AW-1:0] lk_addr0 = '0, lk_addr1 = '0;
  logic          wb_ready, int_ready, exc_ready, rf_we, lk_hit0, lk_hit1;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, lk_data0, lk_data1;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [AW+DW-1:0] sb_q[$];
  logic [AW+DW-1:0] mon_exp;

  rf_write_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .int_valid(int_valid), .int_ready(int_ready), .int_addr(int_addr), .int_data(int_data),
    .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_addr(exc_addr), .exc_data(exc_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lk_addr0(lk_addr0), .lk_addr1(lk_addr1),
    .lk_hit0(lk_hit0), .lk_hit1(lk_hit1), .lk_data0(lk_data0), .lk_data1(lk_data1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every observed write must be the oldest expected one.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rf_write_unexpected: got addr %0d data %h, required no write", rf_waddr, rf_wdata);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({rf_waddr, rf_wdata} !== mon_exp) begin
          tests_failed++;
          $display("FAIL rf_write_value: got addr %0d data %h, required addr %0d data %h",
                   rf_waddr, rf_wdata, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_rf: got we %b addr %0d data %h, required 0", rf_we, rf_waddr, rf_wdata);
    end
    tests_run++;
    if ({wb_ready, int_ready, exc_ready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b, required 111", {wb_ready, int_ready, exc_ready});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_int_alone();
    int_valid = 1'b1; int_addr = 5'd26; int_data = 32'h100;
    sb_q.push_back({5'd26, 32'h100});
    tick();
    int_valid = 1'b0;
    lk_addr0 = 5'd26;
    tests_run++;
    if (int_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL int_ready_busy: got %b, required 0", int_ready);
    end
`ifdef RF_WRITE_BYPASS_EN
    tests_run++;
    if ({lk_hit0, lk_data0} !== {1'b1, 32'h100}) begin
      tests_failed++;
      $display("FAIL lookup_slot: got hit %b data %h, required 1 00000100", lk_hit0, lk_data0);
    end
`endif
    tick();
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd26, 32'h100}) begin
      tests_failed++;
      $display("FAIL int_write: got we %b addr %0d data %h, required 1 26 00000100", rf_we, rf_waddr, rf_wdata);
    end
    tests_run++;
    if (int_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL int_ready_drained: got %b, required 1", int_ready);
    end
    lk_addr0 = '0;
    tick();
  endtask

  task automatic test_starvation();
    int n_acc = 0;
    logic exp_rdy;
    wb_valid = 1'b1; wb_addr = 5'd8;
    int_valid = 1'b1; int_addr = 5'd27; int_data = 32'h200;
    for (int i = 0; i < 8; i++) begin
      wb_data = 32'h1000 + 32'(n_acc);
      exp_rdy = (i != 5);
      tests_run++;
      if (wb_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL starve_wb_ready[%0d]: got %b, required %b", i, wb_ready, exp_rdy);
      end
      if (exp_rdy) begin
        sb_q.push_back({5'd8, wb_data});
        n_acc++;
      end else begin
        sb_q.push_back({5'd27, 32'h200});
      end
      tick();
      int_valid = 1'b0;
    end
    wb_valid = 1'b0;
    tick();
    tests_run++;
    if (int_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL starve_int_ready: got %b, required 1", int_ready);
    end
    tick();
  endtask

  task automatic test_supersede();
    int_valid = 1'b1; int_addr = 5'd26; int_data = 32'hA;
    tick();
    int_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd26; wb_data = 32'hB;
    sb_q.push_back({5'd26, 32'hB});
    tick();
    wb_valid = 1'b0;
    tests_run++;
    if (int_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL supersede_slot_empty: got int_ready %b, required 1", int_ready);
    end
    tick();
    // Same-cycle WB and INT on r9: only WB lands.
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1;
    int_valid = 1'b1; int_addr = 5'd9; int_data = 32'h2;
    sb_q.push_back({5'd9, 32'h1});
    tick();
    wb_valid = 1'b0; int_valid = 1'b0;
    tests_run++;
    if (int_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_wb_int: got int_ready %b, required 1", int_ready);
    end
    tick();
    // Same-cycle INT and EXC on r11: EXC is newer.
    int_valid = 1'b1; int_addr = 5'd11; int_data = 32'h3;
    exc_valid = 1'b1; exc_addr = 5'd11; exc_data = 32'h4;
    sb_q.push_back({5'd11, 32'h4});
    tick();
    int_valid = 1'b0; exc_valid = 1'b0;
    tests_run++;
    if ({int_ready, exc_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL int_exc_same_addr: got int/exc ready %b, required 10", {int_ready, exc_ready});
    end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int_valid = 1'b1; int_addr = 5'd20; int_data = 32'h20;
    exc_valid = 1'b1; exc_addr = 5'd21; exc_data = 32'h21;
    sb_q.push_back({5'd20, 32'h20});
    sb_q.push_back({5'd21, 32'h21});
    tick();
    int_valid = 1'b0; exc_valid = 1'b0;
    tick();
    tests_run++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd20}) begin
      tests_failed++;
      $display("FAIL rr_first: got we %b addr %0d, required 1 20", rf_we, rf_waddr);
    end
    tick();
    tests_run++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd21}) begin
      tests_failed++;
      $display("FAIL rr_second: got we %b addr %0d, required 1 21", rf_we, rf_waddr);
    end
    int_valid = 1'b1; int_addr = 5'd22; int_data = 32'h22;
    exc_valid = 1'b1; exc_addr = 5'd23; exc_data = 32'h23;
    sb_q.push_back({5'd23, 32'h23});
    sb_q.push_back({5'd22, 32'h22});
    tick();
    int_valid = 1'b0; exc_valid = 1'b0;
    tick();
    tests_run++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd23}) begin
      tests_failed++;
      $display("FAIL rr_next_pair: got we %b addr %0d, required 1 23", rf_we, rf_waddr);
    end
    tick();
    tick();
  endtask

  task automatic test_addr_zero();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    int_valid = 1'b1; int_addr = 5'd0; int_data = 32'h5;
    tests_run++;
    if (wb_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_wb_ready: got %b, required 1", wb_ready);
    end
    tick();
    wb_valid = 1'b0; int_valid = 1'b0;
    tests_run++;
    if ({rf_we, int_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL zero_discard: got we %b int_ready %b, required 0 1", rf_we, int_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    exc_valid = 1'b1; exc_addr = 5'd15; exc_data = 32'h77;
    sb_q.push_back({5'd5, 32'h55});
    tick();
    wb_valid = 1'b0; exc_valid = 1'b0;
    lk_addr0 = 5'd15; lk_addr1 = 5'd5;
`ifdef RF_WRITE_BYPASS_EN
    tests_run++;
    if ({lk_hit0, lk_data0, lk_hit1, lk_data1} !== {1'b1, 32'h77, 1'b1, 32'h55}) begin
      tests_failed++;
      $display("FAIL lookup_pre_reset: got %b %h %b %h, required 1 77 1 55", lk_hit0, lk_data0, lk_hit1, lk_data1);
    end
`endif
    rst = 1'b1;
    tick();
    tests_run++;
    if ({rf_we, wb_ready, int_ready, exc_ready, lk_hit0} !== 5'b01110) begin
      tests_failed++;
      $display("FAIL mid_reset: got we/rdy*3/hit %b, required 01110", {rf_we, wb_ready, int_ready, exc_ready, lk_hit0});
    end
    rst = 1'b0;
    lk_addr0 = '0; lk_addr1 = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_int_alone();
    test_starvation();
    test_supersede();
    test_round_robin();
    test_addr_zero();
    test_reset_mid();
    tick();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
